// File: rtl/rcfg_sched.sv
// rcfg_sched: shares a single ICAP bitstream-transfer engine among NREQ
// reconfigurable regions.
//
// A region asks for a module swap by raising req_valid with a module ID. The
// scheduler grants requests round-robin, isolates the granted region, and
// optionally saves its state by reading it back into a per-region save area.
// It then loads the new bitstream described by the module table and
// acknowledges the region.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid[NREQ]      per-region request level, held until req_ack
//   req_modid            per-region module ID, region i at [i*MODW +: MODW]
//   req_save[NREQ]       per-region: read back region state before loading
//   req_ack[NREQ]        one-cycle completion pulse to the granted region
//   req_err[NREQ]        qualifies req_ack: aborted because the entry is empty
//   iso_en[NREQ]         isolation enable of the region being swapped
//   busy                 scheduler not idle
//   tbl_we/idx/baddr/bsize  module-table write port
//   sav_we/idx/baddr/bsize  save-table write port (idx >= NREQ ignored)
//   rc_start             one-cycle engine start pulse
//   rc_bop               1 = load (memory to ICAP), 0 = save (ICAP to memory)
//   rc_baddr, rc_bsize   transfer word address / word count, held between starts
//   rc_done              engine completion pulse
//   dbg_state            current FSM state, for observation only
//
// Handshake: a region keeps req_valid (and its module ID / save flag) stable
// until it sees req_ack, then drops req_valid the following cycle. Towards the
// engine, rc_start is a single-cycle pulse; the next start is issued only
// after rc_done has been seen for the previous one.
module rcfg_sched #(
    parameter int NREQ = 4,
    parameter int MODW = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*MODW-1:0]   req_modid,
    input  logic [NREQ-1:0]        req_save,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        req_err,
    output logic [NREQ-1:0]        iso_en,
    output logic                   busy,
    input  logic                   tbl_we,
    input  logic [MODW-1:0]        tbl_idx,
    input  logic [31:0]            tbl_baddr,
    input  logic [31:0]            tbl_bsize,
    input  logic                   sav_we,
    input  logic [2:0]             sav_idx,
    input  logic [31:0]            sav_baddr,
    input  logic [31:0]            sav_bsize,
    output logic                   rc_start,
    output logic                   rc_bop,
    output logic [31:0]            rc_baddr,
    output logic [31:0]            rc_bsize,
    input  logic                   rc_done,
    output logic [2:0]             dbg_state
);

    localparam int NMOD = 2 ** MODW;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISO     = 3'd1,
        S_SAVE_ST = 3'd2,
        S_SAVE_W  = 3'd3,
        S_LOAD_ST = 3'd4,
        S_LOAD_W  = 3'd5,
        S_REL     = 3'd6,
        S_ACK     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [MODW-1:0] modid_q, modid_d;
    logic            save_q, save_d;
    logic            err_q, err_d;
    logic            rc_bop_q, rc_bop_d;
    logic [31:0]     rc_baddr_q, rc_baddr_d;
    logic [31:0]     rc_bsize_q, rc_bsize_d;

    logic [31:0] tbl_baddr_q [NMOD];
    logic [31:0] tbl_bsize_q [NMOD];
    logic [31:0] tbl_baddr_d [NMOD];
    logic [31:0] tbl_bsize_d [NMOD];
    logic [31:0] sav_baddr_q [NREQ];
    logic [31:0] sav_bsize_q [NREQ];
    logic [31:0] sav_baddr_d [NREQ];
    logic [31:0] sav_bsize_d [NREQ];

    logic [IW-1:0]   pick_idx;
    logic [MODW-1:0] pick_modid;
    logic            pick_save;
    logic            sav_hit;
    logic            tbl_hit;
    logic [NREQ-1:0] gnt_vec;

    // First set request at or above ptr, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && v[IW'(idx)]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Module and save tables. Lookups see the pre-write value in the
    // cycle of a write.
    // ------------------------------------------------------------------
    always_comb begin
        tbl_baddr_d = tbl_baddr_q;
        tbl_bsize_d = tbl_bsize_q;
        sav_baddr_d = sav_baddr_q;
        sav_bsize_d = sav_bsize_q;
        if (tbl_we) begin
            tbl_baddr_d[tbl_idx] = tbl_baddr;
            tbl_bsize_d[tbl_idx] = tbl_bsize;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sav_we && (sav_idx == 3'(i))) begin
                sav_baddr_d[i] = sav_baddr;
                sav_bsize_d[i] = sav_bsize;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NMOD; i++) begin
                tbl_baddr_q[i] <= '0;
                tbl_bsize_q[i] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                sav_baddr_q[i] <= '0;
                sav_bsize_q[i] <= '0;
            end
        end else begin
            tbl_baddr_q <= tbl_baddr_d;
            tbl_bsize_q <= tbl_bsize_d;
            sav_baddr_q <= sav_baddr_d;
            sav_bsize_q <= sav_bsize_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and lookups
    // ------------------------------------------------------------------
    always_comb begin
        pick_idx   = rr_pick(req_valid, rr_ptr_q);
        pick_modid = '0;
        pick_save  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_modid = req_modid[i*MODW +: MODW];
                pick_save  = req_save[i];
            end
        end
    end

    // A save with an empty save area is skipped silently; an empty module
    // entry aborts the request with an error.
    assign sav_hit = save_q && (sav_bsize_q[gidx_q] != '0);
    assign tbl_hit = (tbl_bsize_q[modid_q] != '0);

    // ------------------------------------------------------------------
    // FSM next state. rc_* are loaded on the transition into a start state
    // so they are already valid while rc_start is high.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        modid_d    = modid_q;
        save_d     = save_q;
        err_d      = err_q;
        rc_bop_d   = rc_bop_q;
        rc_baddr_d = rc_baddr_q;
        rc_bsize_d = rc_bsize_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    gidx_d  = pick_idx;
                    modid_d = pick_modid;
                    save_d  = pick_save;
                    state_d = S_ISO;
                end
            end
            S_ISO: begin
                if (sav_hit) begin
                    rc_bop_d   = 1'b0;
                    rc_baddr_d = sav_baddr_q[gidx_q];
                    rc_bsize_d = sav_bsize_q[gidx_q];
                    state_d    = S_SAVE_ST;
                end else if (tbl_hit) begin
                    rc_bop_d   = 1'b1;
                    rc_baddr_d = tbl_baddr_q[modid_q];
                    rc_bsize_d = tbl_bsize_q[modid_q];
                    state_d    = S_LOAD_ST;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_REL;
                end
            end
            S_SAVE_ST: state_d = S_SAVE_W;
            S_SAVE_W: begin
                if (rc_done) begin
                    if (tbl_hit) begin
                        rc_bop_d   = 1'b1;
                        rc_baddr_d = tbl_baddr_q[modid_q];
                        rc_bsize_d = tbl_bsize_q[modid_q];
                        state_d    = S_LOAD_ST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_REL;
                    end
                end
            end
            S_LOAD_ST: state_d = S_LOAD_W;
            S_LOAD_W: begin
                if (rc_done) begin
                    state_d = S_REL;
                end
            end
            S_REL: state_d = S_ACK;
            S_ACK: begin
                rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                err_d    = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            modid_q    <= '0;
            save_q     <= 1'b0;
            err_q      <= 1'b0;
            rc_bop_q   <= 1'b0;
            rc_baddr_q <= '0;
            rc_bsize_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            modid_q    <= modid_d;
            save_q     <= save_d;
            err_q      <= err_d;
            rc_bop_q   <= rc_bop_d;
            rc_baddr_q <= rc_baddr_d;
            rc_bsize_q <= rc_bsize_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        gnt_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_vec[i] = (gidx_q == IW'(i));
        end
    end

    always_comb begin
        iso_en  = '0;
        req_ack = '0;
        req_err = '0;
        if ((state_q != S_IDLE) && (state_q != S_ACK)) begin
            iso_en = gnt_vec;
        end
        if (state_q == S_ACK) begin
            req_ack = gnt_vec;
            req_err = err_q ? gnt_vec : '0;
        end
    end

    assign rc_start  = (state_q == S_SAVE_ST) || (state_q == S_LOAD_ST);
    assign busy      = (state_q != S_IDLE);
    assign rc_bop    = rc_bop_q;
    assign rc_baddr  = rc_baddr_q;
    assign rc_bsize  = rc_bsize_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rcfg_sched.sv
// Testbench for rcfg_sched. Stimulus and responses are handled at the
// falling edge. The reference model works at transaction level: it keeps
// plain copies of both tables and a round-robin pointer, and for each grant
// it predicts the winner, the engine operations in order, and the error flag.
module tb_rcfg_sched;

    localparam int NREQ = 4;
    localparam int MODW = 3;
    localparam int NMOD = 8;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*MODW-1:0] req_modid;
    logic [NREQ-1:0]      req_save;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_err;
    logic [NREQ-1:0]      iso_en;
    logic                 busy;
    logic                 tbl_we;
    logic [MODW-1:0]      tbl_idx;
    logic [31:0]          tbl_baddr;
    logic [31:0]          tbl_bsize;
    logic                 sav_we;
    logic [2:0]           sav_idx;
    logic [31:0]          sav_baddr;
    logic [31:0]          sav_bsize;
    logic                 rc_start;
    logic                 rc_bop;
    logic [31:0]          rc_baddr;
    logic [31:0]          rc_bsize;
    logic                 rc_done;
    logic [2:0]           dbg_state;

    rcfg_sched #(.NREQ(NREQ), .MODW(MODW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_modid (req_modid),
        .req_save  (req_save),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .iso_en    (iso_en),
        .busy      (busy),
        .tbl_we    (tbl_we),
        .tbl_idx   (tbl_idx),
        .tbl_baddr (tbl_baddr),
        .tbl_bsize (tbl_bsize),
        .sav_we    (sav_we),
        .sav_idx   (sav_idx),
        .sav_baddr (sav_baddr),
        .sav_bsize (sav_bsize),
        .rc_start  (rc_start),
        .rc_bop    (rc_bop),
        .rc_baddr  (rc_baddr),
        .rc_bsize  (rc_bsize),
        .rc_done   (rc_done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_tbl_baddr [NMOD];
    logic [31:0] m_tbl_bsize [NMOD];
    logic [31:0] m_sav_baddr [NREQ];
    logic [31:0] m_sav_bsize [NREQ];
    int          m_rr;
    logic [64:0] m_last_op;           // {bop, baddr, bsize} of the last start
    logic [64:0] exp_q[$];            // expected engine operations, in order

    int          eng_min = 0;
    int          eng_max = 0;
    bit          spur_en = 0;
    bit          mid_wr_pending = 0;
    int          mid_wr_idx;
    logic [31:0] mid_wr_baddr;
    logic [31:0] mid_wr_bsize;
    int          last_lat;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NMOD; i++) begin
            m_tbl_baddr[i] = '0;
            m_tbl_bsize[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            m_sav_baddr[i] = '0;
            m_sav_bsize[i] = '0;
        end
        m_rr      = 0;
        m_last_op = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic tbl_write(input int idx, input logic [31:0] ba, input logic [31:0] bs);
        tbl_we    = 1'b1;
        tbl_idx   = MODW'(idx);
        tbl_baddr = ba;
        tbl_bsize = bs;
        @(negedge clk);
        tbl_we = 1'b0;
        m_tbl_baddr[idx] = ba;
        m_tbl_bsize[idx] = bs;
    endtask

    task automatic sav_write(input int idx, input logic [31:0] ba, input logic [31:0] bs);
        sav_we    = 1'b1;
        sav_idx   = 3'(idx);
        sav_baddr = ba;
        sav_bsize = bs;
        @(negedge clk);
        sav_we = 1'b0;
        if (idx < NREQ) begin
            m_sav_baddr[idx] = ba;
            m_sav_bsize[idx] = bs;
        end
    endtask

    task automatic set_req(input int r, input int modid, input bit save);
        req_modid[r*MODW +: MODW] = MODW'(modid);
        req_save[r]  = save;
        req_valid[r] = 1'b1;
    endtask

    // Services one grant, acting as the engine, and checks it end to end.
    // Called at a falling edge with the DUT idle and requests pending; it
    // returns at the falling edge of the idle cycle that follows the ack.
    task automatic service_one();
        int              g;
        int              cyc;
        int              eng_cnt;
        logic [MODW-1:0] mid;
        bit              do_save;
        bit              do_load;
        bit              exp_err;
        bit              ack_seen;
        bit              eng_busy;
        logic [64:0]     op;
        logic [NREQ-1:0] onehot;

        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        end
        if (g < 0) return;

        mid     = req_modid[g*MODW +: MODW];
        do_save = req_save[g] && (m_sav_bsize[g] != 0);
        do_load = (m_tbl_bsize[mid] != 0);
        exp_err = !do_load;
        exp_q.delete();
        if (do_save) exp_q.push_back({1'b0, m_sav_baddr[g], m_sav_bsize[g]});
        if (do_load) exp_q.push_back({1'b1, m_tbl_baddr[mid], m_tbl_bsize[mid]});
        onehot   = NREQ'(1) << g;
        cyc      = 0;
        eng_cnt  = 0;
        ack_seen = 0;
        eng_busy = 0;

        while (!ack_seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            rc_done = 1'b0;
            tbl_we  = 1'b0;
            // Requester scribbles on its module ID after the grant.
            if (cyc == 2) req_modid[g*MODW +: MODW] = MODW'($urandom);

            if (rc_start) begin
                if (eng_busy || exp_q.size() == 0) begin
                    check_eq("unexpected_start", rc_start, 0);
                end else begin
                    op = exp_q.pop_front();
                    check_eq("rc_bop", rc_bop, op[64]);
                    check_eq("rc_baddr", rc_baddr, op[63:32]);
                    check_eq("rc_bsize", rc_bsize, op[31:0]);
                    m_last_op = op;
                    eng_busy  = 1;
                    eng_cnt   = $urandom_range(eng_max, eng_min);
                end
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    rc_done  = 1'b1;
                    eng_busy = 0;
                end else begin
                    eng_cnt--;
                end
                if (mid_wr_pending && m_last_op[64]) begin
                    tbl_we    = 1'b1;
                    tbl_idx   = MODW'(mid_wr_idx);
                    tbl_baddr = mid_wr_baddr;
                    tbl_bsize = mid_wr_bsize;
                    m_tbl_baddr[mid_wr_idx] = mid_wr_baddr;
                    m_tbl_bsize[mid_wr_idx] = mid_wr_bsize;
                    mid_wr_pending = 0;
                end
            end else if (spur_en && $urandom_range(3, 0) == 0) begin
                rc_done = 1'b1;   // must be ignored outside the wait states
            end

            if (req_ack != '0) begin
                ack_seen = 1;
                last_lat = cyc;
                check_eq("req_ack", req_ack, onehot);
                check_eq("req_err", req_err, exp_err ? onehot : '0);
                check_eq("ops_left", exp_q.size(), 0);
                check_eq("iso_at_ack", iso_en, 0);
                check_eq("rc_hold", {rc_bop, rc_baddr, rc_bsize}, m_last_op);
                req_valid[g] = 1'b0;
            end else begin
                check_eq("iso_en", iso_en, onehot);
                check_eq("busy", busy, 1);
            end
        end
        check_eq("ack_timeout", ack_seen, 1);
        req_valid[g] = 1'b0;
        rc_done = 1'b0;
        tbl_we  = 1'b0;
        m_rr    = (g + 1) % NREQ;
        @(negedge clk);
        check_eq("idle_gap_busy", busy, 0);
        check_eq("idle_gap_iso", iso_en, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        rstn      = 1'b0;
        req_valid = '0;
        req_modid = '0;
        req_save  = '0;
        tbl_we    = 1'b0;
        tbl_idx   = '0;
        tbl_baddr = '0;
        tbl_bsize = '0;
        sav_we    = 1'b0;
        sav_idx   = '0;
        sav_baddr = '0;
        sav_bsize = '0;
        rc_done   = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_eq("rst_iso", iso_en, 0);
        check_eq("rst_ack", req_ack, 0);
        check_eq("rst_err", req_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start", rc_start, 0);
        check_eq("rst_rc", {rc_bop, rc_baddr, rc_bsize}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Load only, immediate done: 5 cycles request to ack.
        tbl_write(5, 32'h1000, 64);
        set_req(2, 5, 0);
        service_one();
        check_eq("lat_load", last_lat, 5);

        // Save then load: two extra cycles.
        sav_write(1, 32'h8000, 32);
        tbl_write(3, 32'h2000, 16);
        set_req(1, 3, 1);
        service_one();
        check_eq("lat_save_load", last_lat, 7);

        // Round-robin: bring the pointer to 0, then regions 0 and 3 together.
        set_req(3, 5, 0);
        service_one();
        set_req(0, 5, 0);
        set_req(3, 3, 0);
        service_one();
        service_one();
        // All four continuously requesting.
        for (int r = 0; r < NREQ; r++) set_req(r, 5, r[0]);
        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < NREQ; r++) req_valid[r] = 1'b1;
            service_one();
        end
        req_valid = '0;

        // Zero-size entry: no start, two isolation cycles, error ack.
        set_req(0, 7, 0);
        service_one();
        check_eq("lat_zero", last_lat, 3);

        // Table write during LOAD_W to the active module.
        eng_min = 3;
        eng_max = 3;
        mid_wr_pending = 1;
        mid_wr_idx     = 5;
        mid_wr_baddr   = 32'h3000;
        mid_wr_bsize   = 128;
        set_req(2, 5, 0);
        service_one();
        set_req(2, 5, 0);
        service_one();

        // Save write beyond NREQ is ignored.
        eng_min = 0;
        eng_max = 2;
        sav_write(5, 32'hdead, 9);
        set_req(1, 3, 1);
        service_one();

        // Randomized traffic.
        spur_en = 1;
        eng_max = 4;
        for (int i = 0; i < NMOD; i++)
            tbl_write(i, $urandom, ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(1000, 1));
        for (int i = 0; i < NREQ; i++)
            sav_write(i, $urandom, ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(1000, 1));
        for (int round = 0; round < 30; round++) begin
            req_modid = (NREQ*MODW)'($urandom);
            req_save  = NREQ'($urandom);
            req_valid = NREQ'($urandom_range(15, 1));
            for (int n = 0; n < NREQ && req_valid != '0; n++) begin
                if ($urandom_range(3, 0) == 0) begin
                    mid_wr_pending = 1;
                    mid_wr_idx     = $urandom_range(NMOD - 1, 0);
                    mid_wr_baddr   = $urandom;
                    mid_wr_bsize   = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(1000, 1);
                end
                service_one();
            end
            req_valid = '0;
        end

        // Asynchronous reset while in SAVE_W.
        spur_en = 0;
        mid_wr_pending = 0;
        sav_write(1, 32'h9000, 40);
        tbl_write(5, 32'h1000, 64);
        set_req(1, 5, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rc_start) seen = 1;
        end
        check_eq("save_start_seen", seen, 1);
        check_eq("save_start_bop", rc_bop, 0);
        @(negedge clk);
        check_eq("save_wait_iso", iso_en, 4'b0010);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_iso", iso_en, 0);
        check_eq("arst_start", rc_start, 0);
        check_eq("arst_ack", req_ack, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_rc", {rc_bop, rc_baddr, rc_bsize}, 0);
        req_valid = '0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        // Tables were cleared and the pointer restarts at 0.
        set_req(1, 5, 1);
        set_req(3, 5, 0);
        service_one();
        service_one();
        eng_min = 0;
        eng_max = 0;
        tbl_write(5, 32'h4000, 8);
        set_req(0, 5, 1);
        service_one();
        check_eq("lat_after_rst", last_lat, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
